chacha_aead_seq_ctrl: RTL and testbench

Job sequencer for the ChaCha20-Poly1305 core. It accepts one AEAD job (key, nonce, counter, AAD and payload byte lengths) and configures the core. It then routes a single host 128-bit beat stream into the core's AAD and payload channels, generating byte-keep masks, and builds and issues the lengths block. Finally it collects `tag_pre_xor`/`tagmask` and presents the final tag; a watchdog and an abort input handle hangs.

---
 rtl/chacha_aead_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_chacha_aead_seq_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_aead_seq_ctrl.sv
// Job sequencer for the ChaCha20-Poly1305 core: configures the core, steers the host
// beat stream into the AAD/payload channels, issues the lengths block and collects the tag.
module chacha_aead_seq_ctrl #(
  parameter int unsigned LEN_W   = 32,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [255:0]       key,
  input  logic [95:0]        nonce,
  input  logic [31:0]        ctr_init,
  input  logic [LEN_W-1:0]   aad_len,
  input  logic [LEN_W-1:0]   pld_len,
  input  logic               in_valid,
  input  logic [127:0]       in_data,
  output logic               in_ready,
  output logic               busy,
  output logic [127:0]       tag,
  output logic               tag_valid,
  output logic               timeout_err,
  output logic [255:0]       core_key,
  output logic [95:0]        core_nonce,
  output logic [31:0]        core_ctr_init,
  output logic               core_cfg_we,
  output logic               aad_valid,
  output logic [127:0]       aad_data,
  output logic [15:0]        aad_keep,
  input  logic               aad_ready,
  output logic               pld_valid,
  output logic [127:0]       pld_data,
  output logic [15:0]        pld_keep,
  input  logic               pld_ready,
  output logic               len_valid,
  output logic [127:0]       len_block,
  input  logic               len_ready,
  input  logic [127:0]       tag_pre_xor,
  input  logic               tag_pre_xor_valid,
  input  logic [127:0]       tagmask,
  input  logic               tagmask_valid,
  input  logic               aad_done,
  input  logic               pld_done,
  input  logic               lens_done
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_AAD, S_AAD_WAIT, S_PLD, S_PLD_WAIT, S_LEN, S_TAG, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [255:0]       key_q, key_d;
  logic [95:0]        nonce_q, nonce_d;
  logic [31:0]        ctr_q, ctr_d;
  logic [LEN_W-1:0]   aad_len_q, aad_len_d, pld_len_q, pld_len_d, beat_q, beat_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               aad_flag_q, aad_flag_d, pld_flag_q, pld_flag_d;
  logic               pre_flag_q, pre_flag_d, mask_flag_q, mask_flag_d;
  logic [127:0]       pre_q, pre_d, mask_q, mask_d, tag_q, tag_d;
  logic               busy_q, busy_d, tag_valid_q, tag_valid_d;
  logic               timeout_q, timeout_d, cfg_we_q, cfg_we_d;

  logic [LEN_W-1:0]   cur_len;
  logic               last_beat, beat_hs, progress;
  logic [15:0]        final_keep, cur_keep;
  logic               unused_lens;

  assign unused_lens = lens_done;

  // Channel pass-through and keep generation for the active data phase
  assign cur_len    = (state_q == S_PLD) ? pld_len_q : aad_len_q;
  assign last_beat  = (beat_q == ((cur_len - LEN_W'(1)) >> 4));
  assign final_keep = (cur_len[3:0] == 4'd0) ? 16'hFFFF : 16'((16'd1 << cur_len[3:0]) - 16'd1);
  assign cur_keep   = last_beat ? final_keep : 16'hFFFF;

  assign in_ready  = (state_q == S_AAD) ? aad_ready : ((state_q == S_PLD) ? pld_ready : 1'b0);
  assign beat_hs   = in_valid & in_ready;
  assign aad_valid = (state_q == S_AAD) & in_valid;
  assign pld_valid = (state_q == S_PLD) & in_valid;
  assign aad_data  = in_data;
  assign pld_data  = in_data;
  assign aad_keep  = (state_q == S_AAD) ? cur_keep : 16'h0000;
  assign pld_keep  = (state_q == S_PLD) ? cur_keep : 16'h0000;
  assign len_valid = (state_q == S_LEN);
  assign len_block = {64'(aad_len_q) << 3, 64'(pld_len_q) << 3};

  assign busy          = busy_q;
  assign tag           = tag_q;
  assign tag_valid     = tag_valid_q;
  assign timeout_err   = timeout_q;
  assign core_key      = key_q;
  assign core_nonce    = nonce_q;
  assign core_ctr_init = ctr_q;
  assign core_cfg_we   = cfg_we_q;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    nonce_d     = nonce_q;
    ctr_d       = ctr_q;
    aad_len_d   = aad_len_q;
    pld_len_d   = pld_len_q;
    beat_d      = beat_q;
    wd_d        = wd_q;
    aad_flag_d  = aad_flag_q;
    pld_flag_d  = pld_flag_q;
    pre_flag_d  = pre_flag_q;
    mask_flag_d = mask_flag_q;
    pre_d       = pre_q;
    mask_d      = mask_q;
    tag_d       = tag_q;
    timeout_d   = 1'b0;
    progress    = 1'b0;

    // Done indications are sticky from the first cycle after configuration
    if (state_q != S_IDLE && state_q != S_CFG) begin
      aad_flag_d = aad_flag_q | aad_done;
      pld_flag_d = pld_flag_q | pld_done;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d       = key;
          nonce_d     = nonce;
          ctr_d       = ctr_init;
          aad_len_d   = aad_len;
          pld_len_d   = pld_len;
          aad_flag_d  = 1'b0;
          pld_flag_d  = 1'b0;
          pre_flag_d  = 1'b0;
          mask_flag_d = 1'b0;
          tag_d       = '0;
          state_d     = S_CFG;
        end
      end
      S_CFG: begin
        if (aad_len_q != '0)      state_d = S_AAD;
        else if (pld_len_q != '0) state_d = S_PLD;
        else                      state_d = S_LEN;
      end
      S_AAD, S_PLD: begin
        if (beat_hs) begin
          progress = 1'b1;
          beat_d   = beat_q + LEN_W'(1);
          if (last_beat) state_d = (state_q == S_AAD) ? S_AAD_WAIT : S_PLD_WAIT;
        end
      end
      S_AAD_WAIT: begin
        if (aad_flag_q) state_d = (pld_len_q != '0) ? S_PLD : S_LEN;
      end
      S_PLD_WAIT: begin
        if (pld_flag_q) state_d = S_LEN;
      end
      S_LEN: begin
        if (len_ready) begin
          progress = 1'b1;
          state_d  = S_TAG;
        end
      end
      S_TAG: begin
        progress = tag_pre_xor_valid | tagmask_valid;
        if (!pre_flag_q && tag_pre_xor_valid) begin
          pre_flag_d = 1'b1;
          pre_d      = tag_pre_xor;
        end
        if (!mask_flag_q && tagmask_valid) begin
          mask_flag_d = 1'b1;
          mask_d      = tagmask;
        end
        if (pre_flag_d && mask_flag_d) begin
          tag_d   = pre_d ^ mask_d;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Watchdog: any state change or handshake counts as progress
    if (state_q == S_IDLE) begin
      wd_d = '0;
    end else if (state_d != state_q || progress) begin
      wd_d = '0;
    end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
      wd_d      = '0;
      timeout_d = 1'b1;
      state_d   = S_IDLE;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end

    if (abort) begin
      state_d   = S_IDLE;
      timeout_d = 1'b0;
      wd_d      = '0;
    end

    if (state_d != state_q) beat_d = '0;

    busy_d      = (state_d != S_IDLE);
    tag_valid_d = (state_d == S_DONE);
    cfg_we_d    = (state_d == S_CFG);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      nonce_q     <= '0;
      ctr_q       <= '0;
      aad_len_q   <= '0;
      pld_len_q   <= '0;
      beat_q      <= '0;
      wd_q        <= '0;
      aad_flag_q  <= 1'b0;
      pld_flag_q  <= 1'b0;
      pre_flag_q  <= 1'b0;
      mask_flag_q <= 1'b0;
      pre_q       <= '0;
      mask_q      <= '0;
      tag_q       <= '0;
      busy_q      <= 1'b0;
      tag_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      cfg_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      ctr_q       <= ctr_d;
      aad_len_q   <= aad_len_d;
      pld_len_q   <= pld_len_d;
      beat_q      <= beat_d;
      wd_q        <= wd_d;
      aad_flag_q  <= aad_flag_d;
      pld_flag_q  <= pld_flag_d;
      pre_flag_q  <= pre_flag_d;
      mask_flag_q <= mask_flag_d;
      pre_q       <= pre_d;
      mask_q      <= mask_d;
      tag_q       <= tag_d;
      busy_q      <= busy_d;
      tag_valid_q <= tag_valid_d;
      timeout_q   <= timeout_d;
      cfg_we_q    <= cfg_we_d;
    end
  end

endmodule

// File: tb/tb_chacha_aead_seq_ctrl.sv
// Directed bench for chacha_aead_seq_ctrl: vector table of whole jobs plus hand-written
// sequences for backpressure, tag ordering, watchdog expiry and abort.
module tb_chacha_aead_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst_n, start, abort;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  ctr_init, aad_len, pld_len;
  logic         in_valid, in_ready;
  logic [127:0] in_data;
  logic         busy, tag_valid, timeout_err;
  logic [127:0] tag;
  logic [255:0] core_key;
  logic [95:0]  core_nonce;
  logic [31:0]  core_ctr_init;
  logic         core_cfg_we;
  logic         aad_valid, aad_ready, pld_valid, pld_ready, len_valid, len_ready;
  logic [127:0] aad_data, pld_data, len_block;
  logic [15:0]  aad_keep, pld_keep;
  logic [127:0] tag_pre_xor, tagmask;
  logic         tag_pre_xor_valid, tagmask_valid, aad_done, pld_done, lens_done;

  int n_pass = 0;
  int n_total = 0;

  chacha_aead_seq_ctrl #(.LEN_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .key(key), .nonce(nonce), .ctr_init(ctr_init), .aad_len(aad_len), .pld_len(pld_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .busy(busy), .tag(tag), .tag_valid(tag_valid), .timeout_err(timeout_err),
    .core_key(core_key), .core_nonce(core_nonce), .core_ctr_init(core_ctr_init),
    .core_cfg_we(core_cfg_we),
    .aad_valid(aad_valid), .aad_data(aad_data), .aad_keep(aad_keep), .aad_ready(aad_ready),
    .pld_valid(pld_valid), .pld_data(pld_data), .pld_keep(pld_keep), .pld_ready(pld_ready),
    .len_valid(len_valid), .len_block(len_block), .len_ready(len_ready),
    .tag_pre_xor(tag_pre_xor), .tag_pre_xor_valid(tag_pre_xor_valid),
    .tagmask(tagmask), .tagmask_valid(tagmask_valid),
    .aad_done(aad_done), .pld_done(pld_done), .lens_done(lens_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  aad_len;
    logic [31:0]  pld_len;
    int           aad_beats;
    int           pld_beats;
    logic [15:0]  aad_last_keep;
    logic [15:0]  pld_last_keep;
    logic [127:0] len_block;
    logic [127:0] pre;
    logic [127:0] mask;
    logic [127:0] tag;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] al, input logic [31:0] pl);
    key      = {8{32'hC0DE0000 ^ al}};
    nonce    = {3{32'h5EED0000 ^ pl}};
    ctr_init = 32'd1 + al;
    aad_len  = al;
    pld_len  = pl;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Stream a phase with the core always ready, then pulse done one cycle after the last beat
  task automatic do_phase(input bit is_pld, input int exp_beats, input logic [15:0] exp_keep);
    int n = 0;
    for (int c = 0; c < 40 && n < exp_beats; c++) begin
      in_valid  = 1'b1;
      in_data   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 ^ 128'(n);
      aad_ready = 1'b1;
      pld_ready = 1'b1;
      #1;
      if ((is_pld ? pld_valid : aad_valid) && in_ready) begin
        n++;
        check(is_pld ? "pld_keep" : "aad_keep", 128'(is_pld ? pld_keep : aad_keep),
              128'((n == exp_beats) ? exp_keep : 16'hFFFF));
      end
      step();
    end
    in_valid = 1'b0;
    check(is_pld ? "pld_beats" : "aad_beats", 128'(n), 128'(exp_beats));
    if (is_pld) pld_done = 1'b1;
    else        aad_done = 1'b1;
    step();
    pld_done = 1'b0;
    aad_done = 1'b0;
  endtask

  task automatic wait_len();
    for (int c = 0; c < 20 && !len_valid; c++) step();
    check("len_valid", 128'(len_valid), 128'(1));
  endtask

  task automatic len_hs();
    len_ready = 1'b1;
    step();
    len_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'd0,  32'd0,   0, 0, 16'h0000, 16'h0000, 128'h0,
                {128{1'b1}} & 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5,
                128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A,
                128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF};
    vecs[1] = '{32'd12, 32'd114, 1, 8, 16'h0FFF, 16'h0003, {64'd96, 64'd912},
                128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000,
                128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F,
                128'hF0F00F0F_F0F00F0F_F0F00F0F_F0F00F0F};
    vecs[2] = '{32'd32, 32'd16,  2, 1, 16'hFFFF, 16'hFFFF, {64'd256, 64'd128},
                128'h1, 128'h3, 128'h2};
    vecs[3] = '{32'd17, 32'd0,   2, 0, 16'h0001, 16'h0000, {64'd136, 64'd0},
                128'h0123456789ABCDEF0123456789ABCDEF, 128'h0,
                128'h0123456789ABCDEF0123456789ABCDEF};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    key = '0; nonce = '0; ctr_init = '0; aad_len = '0; pld_len = '0;
    in_valid = 1'b0; in_data = '0; aad_ready = 1'b0; pld_ready = 1'b0; len_ready = 1'b0;
    tag_pre_xor = '0; tagmask = '0; tag_pre_xor_valid = 1'b0; tagmask_valid = 1'b0;
    aad_done = 1'b0; pld_done = 1'b0; lens_done = 1'b0;
    step(); step();

    check("rst_busy",      128'(busy),        128'(0));
    check("rst_tag_valid", 128'(tag_valid),   128'(0));
    check("rst_timeout",   128'(timeout_err), 128'(0));
    check("rst_cfg_we",    128'(core_cfg_we), 128'(0));
    check("rst_valids",    128'({aad_valid, pld_valid, len_valid, in_ready}), 128'(0));
    check("rst_tag",       tag,       128'h0);
    check("rst_len_block", len_block, 128'h0);
    check("rst_core_key",  128'(core_key ^ 256'h0), 128'h0);
    rst_n = 1'b1;
    step();

    // Table of complete jobs, both tag valids in the same cycle
    for (int i = 0; i < 4; i++) begin
      start_job(vecs[i].aad_len, vecs[i].pld_len);
      check("busy_after_start", 128'(busy), 128'(1));
      check("cfg_we",           128'(core_cfg_we), 128'(1));
      check("core_key",         128'(core_key[127:0]), 128'({4{32'hC0DE0000 ^ vecs[i].aad_len}}));
      check("core_ctr",         128'(core_ctr_init), 128'(32'd1 + vecs[i].aad_len));
      step();
      check("cfg_we_pulse",     128'(core_cfg_we), 128'(0));
      if (vecs[i].aad_beats != 0) do_phase(1'b0, vecs[i].aad_beats, vecs[i].aad_last_keep);
      if (vecs[i].pld_beats != 0) do_phase(1'b1, vecs[i].pld_beats, vecs[i].pld_last_keep);
      wait_len();
      check("len_block", len_block, vecs[i].len_block);
      len_hs();
      tag_pre_xor = vecs[i].pre;
      tagmask     = vecs[i].mask;
      tag_pre_xor_valid = 1'b1;
      tagmask_valid     = 1'b1;
      step();
      tag_pre_xor_valid = 1'b0;
      tagmask_valid     = 1'b0;
      check("tag_valid", 128'(tag_valid), 128'(1));
      check("tag",       tag, vecs[i].tag);
      step();
      check("tag_valid_pulse", 128'(tag_valid), 128'(0));
      check("busy_end",        128'(busy), 128'(0));
    end

    // AAD backpressure: aad_ready toggles, done given as a level, mask before pre_xor
    begin
      int hs = 0;
      start_job(32'd32, 32'd0);
      step();
      for (int c = 0; c < 6; c++) begin
        in_valid  = 1'b1;
        in_data   = 128'hAAAA_0000_0000_0000_0000_0000_0000_0000 ^ 128'(hs);
        aad_ready = (c % 2 == 0);
        #1;
        if (c < 3) begin
          check("in_ready_mirror", 128'(in_ready), 128'(aad_ready));
          check("aad_data_pass",   aad_data, in_data);
        end
        if (aad_valid && aad_ready) hs++;
        step();
      end
      in_valid = 1'b0;
      aad_ready = 1'b0;
      check("toggle_hs_count", 128'(hs), 128'(2));
      aad_done = 1'b1;
      wait_len();
      aad_done = 1'b0;
      check("len_block_32", len_block, {64'd256, 64'd0});
      len_hs();
      tagmask = 128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF;
      tagmask_valid = 1'b1;
      step();
      tagmask_valid = 1'b0;
      tagmask = '0;
      for (int c = 0; c < 2; c++) begin
        check("tag_wait_pre", 128'(tag_valid), 128'(0));
        step();
      end
      tag_pre_xor = 128'h12345678_12345678_12345678_12345678;
      tag_pre_xor_valid = 1'b1;
      step();
      tag_pre_xor_valid = 1'b0;
      check("tag_order_valid", 128'(tag_valid), 128'(1));
      check("tag_order",       tag, 128'h1234A987_1234A987_1234A987_1234A987);
      step();
    end

    // Watchdog: len_ready held low after entering LEN
    begin
      int tv = 0;
      start_job(32'd0, 32'd0);
      step();
      check("wd_len_entry", 128'(len_valid), 128'(1));
      for (int k = 1; k <= 16; k++) begin
        step();
        tv += int'(tag_valid);
        if (k < 16) check("wd_no_early", 128'(timeout_err), 128'(0));
      end
      check("wd_timeout", 128'(timeout_err), 128'(1));
      check("wd_busy",    128'(busy),        128'(0));
      step();
      tv += int'(tag_valid);
      check("wd_timeout_pulse", 128'(timeout_err), 128'(0));
      check("wd_no_tag",        128'(tv),          128'(0));
    end

    // Abort on payload beat 3 with a stale pld_done seen, then a clean job
    begin
      int n = 0;
      start_job(32'd0, 32'd64);
      step();
      for (int c = 0; c < 10 && n < 2; c++) begin
        in_valid = 1'b1;
        pld_ready = 1'b1;
        pld_done = (n == 0);
        #1;
        if (pld_valid && in_ready) n++;
        step();
      end
      pld_done = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      in_valid = 1'b0;
      check("abort_idle",     128'(busy),      128'(0));
      check("abort_in_ready", 128'(in_ready),  128'(0));
      check("abort_no_tag",   128'(tag_valid), 128'(0));
      check("abort_no_to",    128'(timeout_err), 128'(0));
      step();
      start_job(32'd0, 32'd16);
      step();
      in_valid = 1'b1;
      #1;
      check("post_abort_keep", 128'(pld_keep), 128'(16'hFFFF));
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
        check("no_flag_leak", 128'(len_valid), 128'(0));
        step();
      end
      pld_done = 1'b1;
      step();
      pld_done = 1'b0;
      wait_len();
      check("post_abort_len", len_block, {64'd0, 64'd128});
      len_hs();
      tag_pre_xor = 128'hF;
      tagmask = 128'hF0;
      tag_pre_xor_valid = 1'b1;
      tagmask_valid = 1'b1;
      step();
      tag_pre_xor_valid = 1'b0;
      tagmask_valid = 1'b0;
      check("post_abort_tag", tag, 128'hFF);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
